// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin arbiter that shares one N-bit register between
//               NREQ writers through a request/ack handshake. The winning
//               word is presented on reg_d with reg_we high for exactly one
//               cycle. A locked requester may burst up to MAX_BURST
//               back-to-back writes. The post-write register value is
//               returned on rdata together with ack.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous, active-low reset
//               req    - per-requester write request (level)
//               lock   - per-requester burst hold (honoured for the owner only)
//               wdata  - write data, requester i on bits [i*N +: N]
//               gnt    - one-hot grant, high through WRITE and ACK
//               ack    - one-cycle completion pulse for the owner
//               rdata  - register value after the write, valid with ack
//               busy   - high in WRITE or ACK
//               reg_d  - register data input
//               reg_we - register write enable
//               reg_q  - register output
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int N         = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*N-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [N-1:0]      rdata,
    output logic              busy,
    output logic [N-1:0]      reg_d,
    output logic              reg_we,
    input  logic [N-1:0]      reg_q
);

    localparam int c_IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NREQ-1:0]      r_gnt;
    logic [c_IDX_W-1:0]   r_owner;      // current winner; doubles as "last" pointer
    logic [c_CNT_W-1:0]   r_burst_cnt;
    logic [N-1:0]         r_reg_d;

    logic [N-1:0]         w_lane [NREQ];
    logic [c_IDX_W-1:0]   w_scan_idx;
    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_found;
    logic                 w_keep;
    logic                 w_grant_new;
    logic                 w_continue;
    logic                 w_release;

    // Split the flat write-data bus into per-requester words.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign w_lane[gi] = wdata[gi*N +: N];
        end
    endgenerate

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        w_found    = 1'b0;
        w_winner   = r_owner;
        w_scan_idx = r_owner;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan_idx = c_IDX_W'((int'(r_owner) + k) % NREQ);
            if (!w_found && req[w_scan_idx]) begin
                w_found  = 1'b1;
                w_winner = w_scan_idx;
            end
        end
    end

    // The owner keeps the grant only while it still asks for it, holds lock,
    // and has burst budget left.
    assign w_keep = lock[r_owner] && req[r_owner] &&
                    (r_burst_cnt < c_CNT_W'(MAX_BURST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_new = 1'b0;
        w_continue  = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_WRITE;
                    w_grant_new = 1'b1;
                end
            end
            ST_WRITE: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (w_keep) begin
                    w_state_nxt = ST_WRITE;
                    w_continue  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_release   = 1'b1;
            end
        endcase
    end

    // Grant, pointer, burst counter and the latched write word. reg_d is
    // captured only when entering WRITE so later wdata changes cannot leak in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt       <= '0;
            r_owner     <= c_IDX_W'(NREQ - 1);
            r_burst_cnt <= '0;
            r_reg_d     <= '0;
        end else if (w_grant_new) begin
            r_gnt       <= NREQ'(1) << w_winner;
            r_owner     <= w_winner;
            r_burst_cnt <= c_CNT_W'(1);
            r_reg_d     <= w_lane[w_winner];
        end else if (w_continue) begin
            r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
            r_reg_d     <= w_lane[r_owner];
        end else if (w_release) begin
            r_gnt       <= '0;
            r_burst_cnt <= '0;
        end
    end

    assign gnt    = r_gnt;
    assign busy   = (r_state != ST_IDLE);
    assign reg_we = (r_state == ST_WRITE);
    assign reg_d  = r_reg_d;
    // In ACK the register has already captured the word, so reg_q is the
    // post-write value.
    assign ack    = (r_state == ST_ACK) ? r_gnt : '0;
    assign rdata  = (r_state == ST_ACK) ? reg_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter: directed vector
//               table, hand-written multi-cycle sequences, and a randomized
//               phase compared against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int N         = 32;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;

    logic              clk   = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req   = '0;
    logic [NREQ-1:0]   lock  = '0;
    logic [NREQ*N-1:0] wdata = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [N-1:0]      rdata;
    logic              busy;
    logic [N-1:0]      reg_d;
    logic              reg_we;
    logic [N-1:0]      reg_q;
    logic [N-1:0]      reg_store = '0;

    int n_cmp = 0;
    int n_bad = 0;

    reg_write_arbiter #(.N(N), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
        .reg_d(reg_d), .reg_we(reg_we), .reg_q(reg_q)
    );

    always #5 clk = ~clk;

    // The shared register itself; not affected by the arbiter's reset.
    always_ff @(posedge clk) if (reg_we) reg_store <= reg_d;
    assign reg_q = reg_store;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [N-1:0] v);
        wdata[i*N +: N] = v;
    endtask

    function automatic int first_bit(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; req = '0; lock = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    // phase: 0 idle, 1 write cycle, 2 ack cycle; owner -1 when nobody holds it.
    int           m_phase, m_owner, m_last, m_cnt;
    logic [N-1:0] m_data, m_reg;

    task automatic model_reset();
        m_phase = 0; m_owner = -1; m_last = NREQ - 1; m_cnt = 0;
        m_data = '0; m_reg = reg_store;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                              input logic [NREQ*N-1:0] wd);
        int order[$];
        if (m_phase == 1) m_reg = m_data;
        case (m_phase)
            0: begin
                for (int k = 1; k <= NREQ; k++) order.push_back((m_last + k) % NREQ);
                foreach (order[j]) begin
                    if (m_phase == 0 && r[order[j]]) begin
                        m_owner = order[j]; m_last = order[j]; m_cnt = 1;
                        m_data = wd[order[j]*N +: N]; m_phase = 1;
                    end
                end
            end
            1: m_phase = 2;
            default: begin
                if (l[m_owner] && r[m_owner] && m_cnt < MAX_BURST) begin
                    m_phase = 1; m_cnt++; m_data = wd[m_owner*N +: N];
                end else begin
                    m_phase = 0; m_owner = -1; m_cnt = 0;
                end
            end
        endcase
    endtask

    task automatic model_check();
        logic [NREQ-1:0] eg;
        eg = (m_phase != 0) ? (NREQ'(1) << m_owner) : '0;
        chk("rnd gnt",    gnt,    eg);
        chk("rnd ack",    ack,    (m_phase == 2) ? eg : '0);
        chk("rnd reg_we", reg_we, m_phase == 1);
        chk("rnd busy",   busy,   m_phase != 0);
        chk("rnd reg_d",  reg_d,  m_data);
        if (m_phase == 2) chk("rnd rdata", rdata, m_reg);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NREQ-1:0] req;
        logic [N-1:0]    base;
        logic [NREQ-1:0] exp_gnt;
        logic [N-1:0]    exp_data;
    } vec_t;

    vec_t vecs[7];

    int ack_who[$];
    int ack_t[$];

    initial begin
        // Table assumes a fresh reset (pointer at NREQ-1); lane i carries base+i.
        vecs[0] = '{4'b0001, 32'h100,       4'b0001, 32'h100};
        vecs[1] = '{4'b0011, 32'h200,       4'b0010, 32'h201};
        vecs[2] = '{4'b0011, 32'h300,       4'b0001, 32'h300};
        vecs[3] = '{4'b1100, 32'h400,       4'b0100, 32'h402};
        vecs[4] = '{4'b1111, 32'h500,       4'b1000, 32'h503};
        vecs[5] = '{4'b1001, 32'h600,       4'b0001, 32'h600};
        vecs[6] = '{4'b1000, 32'hFFFF_FFF0, 4'b1000, 32'hFFFF_FFF3};

        // 1: reset state, idle with no requests
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t1 gnt", gnt, 0);
            chk("t1 reg_we", reg_we, 0);
            chk("t1 busy", busy, 0);
            chk("t1 reg_d", reg_d, 0);
        end

        // 2: single write by requester 0
        req = 4'b0001; set_lane(0, 32'd21512);
        @(negedge clk);
        chk("t2 reg_we", reg_we, 1);
        chk("t2 reg_d", reg_d, 21512);
        chk("t2 gnt", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        chk("t2 ack", ack, 4'b0001);
        chk("t2 rdata", rdata, 21512);
        chk("t2 reg_we low", reg_we, 0);
        @(negedge clk);
        chk("t2 idle busy", busy, 0);
        chk("t2 idle gnt", gnt, 0);

        // Table of single transactions
        do_reset();
        foreach (vecs[v]) begin
            req = vecs[v].req;
            for (int i = 0; i < NREQ; i++) set_lane(i, vecs[v].base + N'(i));
            @(negedge clk);
            chk("tab gnt", gnt, vecs[v].exp_gnt);
            chk("tab reg_we", reg_we, 1);
            chk("tab reg_d", reg_d, vecs[v].exp_data);
            req = '0;
            @(negedge clk);
            chk("tab ack", ack, vecs[v].exp_gnt);
            chk("tab rdata", rdata, vecs[v].exp_data);
            @(negedge clk);
            chk("tab busy", busy, 0);
        end

        // 3: all requesting, no lock -> 0,1,2,3,0 spaced 3 cycles
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, 32'hA000 + N'(i));
        req = 4'b1111;
        ack_who.delete(); ack_t.delete();
        for (int c = 0; c < 40 && ack_who.size() < 5; c++) begin
            @(negedge clk);
            if (ack != 0) begin ack_who.push_back(first_bit(ack)); ack_t.push_back(c); end
        end
        chk("t3 ack count", ack_who.size(), 5);
        if (ack_who.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t3 order", ack_who[i], i % NREQ);
            for (int i = 1; i < 5; i++) chk("t3 spacing", ack_t[i] - ack_t[i-1], 3);
        end
        req = '0;

        // 4: locked burst by 2 capped at MAX_BURST, then 3 gets a turn
        do_reset();
        req = 4'b1100; lock = 4'b0100;
        ack_who.delete(); ack_t.delete();
        for (int c = 0; c < 40 && ack_who.size() < 5; c++) begin
            @(negedge clk);
            if (ack != 0) begin ack_who.push_back(first_bit(ack)); ack_t.push_back(c); end
        end
        chk("t4 ack count", ack_who.size(), 5);
        if (ack_who.size() == 5) begin
            for (int i = 0; i < 4; i++) chk("t4 burst owner", ack_who[i], 2);
            chk("t4 next owner", ack_who[4], 3);
            for (int i = 1; i < 4; i++) chk("t4 burst spacing", ack_t[i] - ack_t[i-1], 2);
            chk("t4 handover spacing", ack_t[4] - ack_t[3], 3);
        end
        req = '0; lock = '0;

        // 5: reset in the middle of a write
        do_reset();
        req = 4'b0010; set_lane(1, 32'h1111);
        @(negedge clk);
        chk("t5 in write", reg_we, 1);
        reset = 1'b0;
        #1;
        chk("t5 reg_we drop", reg_we, 0);
        chk("t5 gnt drop", gnt, 0);
        chk("t5 busy drop", busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5 no ack", ack, 0);
        end
        reset = 1'b1; req = 4'b0011; set_lane(0, 32'h2222);
        @(negedge clk);
        chk("t5 regrant", gnt, 4'b0001);
        req = '0;
        @(negedge clk);
        chk("t5 ack0", ack, 4'b0001);
        @(negedge clk);

        // 6: wdata change during WRITE is ignored
        req = 4'b0001; set_lane(0, 32'd2254);
        @(negedge clk);
        chk("t6 reg_d", reg_d, 2254);
        set_lane(0, 32'd234522); req = '0;
        #1;
        chk("t6 reg_d held", reg_d, 2254);
        @(negedge clk);
        chk("t6 rdata", rdata, 2254);
        chk("t6 register", reg_q, 2254);
        @(negedge clk);

        // Randomized phase against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            model_check();
            req  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom_range(0, 15));
            lock = NREQ'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) set_lane(i, N'($urandom));
            model_step(req, lock, wdata);
            @(negedge clk);
        end
        model_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
